// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcode constants, fetch state encoding and reset PC shared by the fetch unit
package fetch_unit_pkg;
   localparam logic [6:0] OPC_FENCE = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   typedef enum logic [1:0] {FETCH, WAIT, DISCARD, HALT} fetch_state_e;
   function automatic logic is_halt(input logic [6:0] opcode);
      return opcode == OPC_FENCE || opcode == OPC_SYSTEM;
   endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory, redirect and decode handshake bundle
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        halted;
   modport master (
      output imem_req, imem_addr, id_valid, id_pc, id_instr, halted,
      input  imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
   );
   modport slave (
      input  imem_req, imem_addr, id_valid, id_pc, id_instr, halted,
      output imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: {pc, instr} buffer between memory and decode, flushable on redirect
module fetch_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [63:0]              din,
   output logic [63:0]              dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
   logic [63:0] mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [AW:0] cnt_q, cnt_d;
   logic wr_en, rd_en;
   assign wr_en = push && !full && !flush;
   assign rd_en = pop && !empty && !flush;
   assign count = cnt_q;
   assign full = cnt_q == FULL_CNT;
   assign empty = cnt_q == '0;
   assign dout = mem_q[rd_q];
   // pointer and occupancy update; flush discards everything
   always_comb begin
      rd_d = flush ? '0 : rd_q + AW'(rd_en);
      wr_d = flush ? '0 : wr_q + AW'(wr_en);
      cnt_d = flush ? '0 : cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
   end
   // pointer and count registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
         cnt_q <= cnt_d;
      end
   end
   // storage array, contents only meaningful below the count
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= din;
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect flush, halt detection and decode buffer
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int FIFO_DEPTH = 4
) (
   input logic clk,
   input logic rst,
   fetch_unit_if.master bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   fetch_state_e state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d, tgt_q, tgt_d, redir_pc;
   logic started_q;
   logic ack, push, pop, full, empty;
   logic [CW-1:0] count;
   logic [63:0] head;
   assign redir_pc = bus.redirect_pc & ~32'h3;
   assign bus.imem_req = started_q && (state_q == WAIT || state_q == DISCARD || (state_q == FETCH && !full));
   assign bus.imem_addr = fetch_pc_q;
   assign ack = bus.imem_req && bus.imem_ack;
   assign push = ack && !bus.redirect_valid && state_q != DISCARD;
   assign pop = count != '0 && bus.id_ready && !bus.redirect_valid;
   assign bus.id_valid = !empty;
   assign bus.id_pc = empty ? '0 : head[63:32];
   assign bus.id_instr = empty ? '0 : head[31:0];
   assign bus.halted = state_q == HALT;
   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .flush(bus.redirect_valid),
      .push(push),
      .pop(pop),
      .din({fetch_pc_q, bus.imem_rdata}),
      .dout(head),
      .count(count),
      .full(full),
      .empty(empty)
   );
   // next state: DISCARD keeps the stale address on the bus and parks the new target in tgt
   always_comb begin
      state_d = state_q;
      fetch_pc_d = fetch_pc_q;
      tgt_d = tgt_q;
      if (state_q == DISCARD) begin
         if (bus.redirect_valid) tgt_d = redir_pc;
         if (ack) begin
            state_d = FETCH;
            fetch_pc_d = bus.redirect_valid ? redir_pc : tgt_q;
         end
      end else if (bus.redirect_valid) begin
         if (bus.imem_req && !ack) begin
            state_d = DISCARD;
            tgt_d = redir_pc;
         end else begin
            state_d = FETCH;
            fetch_pc_d = redir_pc;
         end
      end else if (ack) begin
         state_d = is_halt(bus.imem_rdata[6:0]) ? HALT : FETCH;
         fetch_pc_d = fetch_pc_q + 32'd4;
      end else if (bus.imem_req) begin
         state_d = WAIT;
      end
   end
   // FSM registers; started_q holds off the first request until one edge after reset release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH;
         fetch_pc_q <= RESET_PC;
         tgt_q <= RESET_PC;
         started_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fetch_pc_q <= fetch_pc_d;
         tgt_q <= tgt_d;
         started_q <= 1'b1;
      end
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ack  input  1  read complete, imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 id_valid  output  1  head entry presented to decode stage.
REQ-012 id_ready  input  1  decode stage accepts head entry.
REQ-013 id_pc  output  32  PC of head entry.
REQ-014 id_instr  output  32  instruction of head entry.
REQ-015 halted  output  1  fetch stopped on halt instruction.

Function
REQ-016 SHALL implement states FETCH, WAIT, DISCARD, HALT.
REQ-017 FETCH: imem_req=1, imem_addr=fetch_pc, only when FIFO count < FIFO_DEPTH; otherwise imem_req=0, stay FETCH.
REQ-018 imem_ack may arrive in the request cycle (zero wait) or any later cycle; at most one request outstanding.
REQ-019 Request without same-cycle ack -> WAIT; imem_req and imem_addr held stable until imem_ack.
REQ-020 On imem_ack (FETCH or WAIT): enqueue {fetch_pc, imem_rdata}, fetch_pc += 4 (mod 2^32), next state FETCH.
REQ-021 Enqueued word with opcode[6:0] 7'b0001111 or 7'b1110011 -> HALT; no further requests; halted=1 while in HALT.
REQ-022 Dequeue when id_valid && id_ready; id_valid = FIFO not empty; id_pc/id_instr = head, 0 when empty.
REQ-023 Enqueue and dequeue in the same cycle SHALL both take effect; count unchanged.
REQ-024 redirect_valid SHALL win over enqueue and dequeue: FIFO emptied, id_valid=0 next cycle, fetch_pc = {redirect_pc[31:2], 2'b00}.
REQ-025 Redirect while WAIT without same-cycle ack -> DISCARD: old request held until ack, returned data dropped, then FETCH at new PC.
REQ-026 Redirect in same cycle as imem_ack SHALL drop that data; next state FETCH.
REQ-027 Redirect in HALT -> FETCH, halted=0 next cycle; redirect in DISCARD updates target, stays DISCARD.
REQ-028 First request after redirect (non-DISCARD) SHALL issue the following cycle.
REQ-029 Throughput: one instruction per cycle with zero-wait memory and id_ready=1.

Reset
REQ-030 rst low SHALL immediately force: state FETCH, fetch_pc=RESET_PC, FIFO empty, imem_req=0, id_valid=0, id_pc=0, id_instr=0, halted=0.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; any later imem_ack for it is ignored until a new request issues.
REQ-032 First imem_req SHALL assert in the first clock edge's cycle after rst deasserts.

Structure
REQ-033 Shared package: OPC_FENCE, OPC_SYSTEM opcode constants, fetch state enum, default RESET_PC.
REQ-034 Sub-module fetch_fifo: synchronous 64-bit FIFO, depth FIFO_DEPTH, with flush, count, full/empty.

Verification
REQ-035 Reset, zero-wait memory, id_ready=1 -> addresses 0,4,8,... one per cycle; id_pc lags imem_addr by one cycle.
REQ-036 id_ready=0 for 10 cycles -> exactly 4 entries (PC 0..C) buffered, imem_req=0 after full; release -> in-order delivery, no loss.
REQ-037 imem_ack delayed 3 cycles -> imem_addr constant during wait; redirect_pc=0x40 in wait cycle 1 -> stale word dropped, next request addr 0x40.
REQ-038 imem_rdata=0x0000_0073 at PC 0x10 -> halted=1, no request for 0x14; redirect to 0x20 -> halted=0, fetch 0x20.
REQ-039 redirect_pc=0x33 same cycle as ack and dequeue -> FIFO empty, id_valid=0, next imem_addr=0x30.
REQ-040 rst low during WAIT -> imem_req=0 asynchronously; after release fetch restarts at RESET_PC, late ack ignored.
